// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
//   Forwarding and load-use hazard unit that sits beside the EX stage. It keeps
//   a private tag pipeline ({valid, rd, regwrite, load}) for the FWD_STAGES
//   stages after EX (stage 1 = MEM, stage 2 = WB, ...). From that pipeline it
//   derives a per-operand bypass select and a stall request.
//
//   Optional feature: define FWD_STATS_EN to build the stall/forward
//   statistics counters. Without it, both counter ports read 0.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   ex_valid     EX holds a live instruction
//   ex_src       operand register addresses, operand i at [i*REG_AW +: REG_AW]
//   ex_rd        EX destination register
//   ex_regwrite  EX instruction writes the register file
//   ex_memread   EX instruction is a load
//   fwd_sel      per-operand select, SELW bits each; 0 = regfile, k = stage k
//   stall        freeze PC/IF/ID/EX; a bubble enters stage 1
//   stall_cnt    saturating count of stall cycles (FWD_STATS_EN)
//   fwd_cnt      saturating count of cycles with any non-zero select (FWD_STATS_EN)
module fwd_hazard_unit #(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned LOAD_READY = 2,
  parameter int unsigned CNT_W      = 16,
  localparam int unsigned SELW      = $clog2(FWD_STAGES + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ex_valid,
  input  logic [NUM_SRC*REG_AW-1:0] ex_src,
  input  logic [REG_AW-1:0]         ex_rd,
  input  logic                      ex_regwrite,
  input  logic                      ex_memread,
  output logic [NUM_SRC*SELW-1:0]   fwd_sel,
  output logic                      stall,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          fwd_cnt
);

  if (FWD_STAGES < 1 || FWD_STAGES > 7) begin : g_bad_fwd_stages
    $error("fwd_hazard_unit: FWD_STAGES must be in 1..7");
  end
  if (LOAD_READY < 1 || LOAD_READY > FWD_STAGES) begin : g_bad_load_ready
    $error("fwd_hazard_unit: LOAD_READY must be in 1..FWD_STAGES");
  end

  // Tag pipeline, index 1 is the youngest (MEM) stage.
  logic [FWD_STAGES:1] v_q;
  logic [FWD_STAGES:1] rw_q;
  logic [FWD_STAGES:1] ld_q;
  logic [REG_AW-1:0]   rd_q [1:FWD_STAGES];

  logic [REG_AW-1:0] src_cur;
  logic              found;
  int unsigned       win_k;
  logic              win_ld;
  logic              stall_req;

  // Scan from the youngest stage upwards; the first hit wins. A load hit that
  // is younger than LOAD_READY holds the select at 0 and requests a stall.
  always_comb begin
    fwd_sel   = '0;
    stall_req = 1'b0;
    src_cur   = '0;
    found     = 1'b0;
    win_k     = 0;
    win_ld    = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      src_cur = ex_src[i*REG_AW +: REG_AW];
      found   = 1'b0;
      win_k   = 0;
      win_ld  = 1'b0;
      for (int unsigned k = 1; k <= FWD_STAGES; k++) begin
        if (!found && v_q[k] && rw_q[k] && (rd_q[k] != '0) && (rd_q[k] == src_cur)) begin
          found  = 1'b1;
          win_k  = k;
          win_ld = ld_q[k];
        end
      end
      if (found && win_ld && (win_k < LOAD_READY)) begin
        stall_req = 1'b1;
      end else if (found) begin
        fwd_sel[i*SELW +: SELW] = SELW'(win_k);
      end
    end
  end

  assign stall = ex_valid & stall_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q  <= '0;
      rw_q <= '0;
      ld_q <= '0;
      for (int unsigned k = 1; k <= FWD_STAGES; k++) begin
        rd_q[k] <= '0;
      end
    end else begin
      // A stalled EX instruction stays in EX, so only a bubble moves forward.
      v_q[1]  <= ex_valid & ~stall;
      rd_q[1] <= ex_rd;
      rw_q[1] <= ex_regwrite;
      ld_q[1] <= ex_memread;
      for (int unsigned k = 2; k <= FWD_STAGES; k++) begin
        v_q[k]  <= v_q[k-1];
        rd_q[k] <= rd_q[k-1];
        rw_q[k] <= rw_q[k-1];
        ld_q[k] <= ld_q[k-1];
      end
    end
  end

`ifdef FWD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] fwd_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if ((|fwd_sel) && (fwd_cnt_q != '1)) begin
        fwd_cnt_q <= fwd_cnt_q + 1'b1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`else
  assign stall_cnt = '0;
  assign fwd_cnt   = '0;
`endif

endmodule
